// File: rtl/lsu_ctrl.sv
// Load/store control stage: one request at a time, alignment (and optional range) check,
// single-cycle RAM strobe, response to writeback. Optional range check: LSU_RANGE_CHECK_EN.
module lsu_ctrl #(
   parameter int unsigned DMEM_BYTES = 8192
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_sign,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        ram_we,
   output logic        ram_re,
   output logic [3:0]  ram_type,
   output logic        sign,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdat,
   input  logic [31:0] data_reg,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic        resp_is_load,
   output logic        exc_valid,
   output logic [1:0]  exc_cause,
   output logic [31:0] exc_addr
);

`ifdef LSU_RANGE_CHECK_EN
   localparam bit RANGE_EN = 1'b1;
`else
   localparam bit RANGE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'b00,
      CAUSE_LD_MIS = 2'b01,
      CAUSE_ST_MIS = 2'b10,
      CAUSE_FAULT  = 2'b11
   } cause_t;

   state_t     state;
   logic       we_q;
   logic [2:0] last_off;
   logic [3:0] req_type;
   logic       misaligned;
   logic       out_of_range;
   logic       fault;
   cause_t     cause;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      last_off = 3'd3;
      req_type = 4'b1111;
      case (req_size)
         2'b00:   begin last_off = 3'd0; req_type = 4'b0001; end
         2'b01:   begin last_off = 3'd1; req_type = 4'b0011; end
         default: ;
      endcase
      // last_off doubles as the low-address mask that must be zero for an aligned access
      misaligned   = |(req_addr[1:0] & last_off[1:0]);
      out_of_range = RANGE_EN &&
                     (({1'b0, req_addr} + {30'd0, last_off}) >= 33'(DMEM_BYTES));
      fault        = misaligned | out_of_range;
      if (misaligned)        cause = req_we ? CAUSE_ST_MIS : CAUSE_LD_MIS;
      else if (out_of_range) cause = CAUSE_FAULT;
      else                   cause = CAUSE_NONE;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         we_q         <= 1'b0;
         req_ready    <= 1'b1;
         ram_we       <= 1'b0;
         ram_re       <= 1'b0;
         ram_type     <= 4'b0000;
         sign         <= 1'b0;
         ram_addr     <= '0;
         ram_wdat     <= '0;
         resp_valid   <= 1'b0;
         resp_rdata   <= '0;
         resp_rd      <= '0;
         resp_is_load <= 1'b0;
         exc_valid    <= 1'b0;
         exc_cause    <= 2'b00;
         exc_addr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready    <= 1'b0;
                  we_q         <= req_we;
                  resp_rd      <= req_rd;
                  resp_is_load <= ~req_we;
                  resp_rdata   <= '0;
                  exc_valid    <= fault;
                  exc_cause    <= cause;
                  exc_addr     <= fault ? req_addr : 32'd0;
                  if (fault) begin
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     // RAM lines are loaded here so they are live for exactly the ISSUE cycle
                     ram_we   <= req_we;
                     ram_re   <= ~req_we;
                     ram_type <= req_type;
                     sign     <= req_sign & ~req_we;
                     ram_addr <= req_addr;
                     ram_wdat <= req_wdata;
                     state    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               ram_we   <= 1'b0;
               ram_re   <= 1'b0;
               ram_type <= 4'b0000;
               sign     <= 1'b0;
               if (we_q) begin
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  state <= CAPTURE;
               end
            end
            CAPTURE: begin
               resp_rdata <= data_reg;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  exc_valid  <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, reset-mid-load sequence,
// and random requests against a byte-addressed RAM model.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        ram_we;
   logic        ram_re;
   logic [3:0]  ram_type;
   logic        sign;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdat;
   logic [31:0] data_reg;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_is_load;
   logic        exc_valid;
   logic [1:0]  exc_cause;
   logic [31:0] exc_addr;

   int vectors;
   int miscompares;

`ifdef LSU_RANGE_CHECK_EN
   localparam bit         RANGE_EN = 1'b1;
   localparam logic [1:0] RC       = 2'b11;
`else
   localparam bit         RANGE_EN = 1'b0;
   localparam logic [1:0] RC       = 2'b00;
`endif
   localparam longint DMEM = 8192;

   lsu_ctrl #(.DMEM_BYTES(8192)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_rd(req_rd),
      .ram_we(ram_we), .ram_re(ram_re), .ram_type(ram_type), .sign(sign),
      .ram_addr(ram_addr), .ram_wdat(ram_wdat), .data_reg(data_reg),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_rd(resp_rd), .resp_is_load(resp_is_load),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [bit [31:0]];

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      int          stall;
      logic [1:0]  exp_cause;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   // RAM model: little-endian bytes, extended to 32 bits as the real RAM does
   function automatic logic [31:0] ram_read(input logic [31:0] addr, input int nb, input logic sgn);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < nb; i++)
         v[8*i +: 8] = mem.exists(addr + 32'(i)) ? mem[addr + 32'(i)] : 8'h00;
      if (nb < 4 && sgn && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
      return v;
   endfunction

   function automatic logic [1:0] model_cause(input logic we, input logic [1:0] size,
                                              input logic [31:0] addr);
      int nb;
      nb = nbytes(size);
      if ((longint'(addr) % nb) != 0)                      return we ? 2'b10 : 2'b01;
      if (RANGE_EN && (longint'(addr) + nb - 1 >= DMEM))   return 2'b11;
      return 2'b00;
   endfunction

   task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int stall, input logic [1:0] exp_cause, input logic [31:0] exp_rdata);
      int nb;
      logic [31:0] ram_val;
      nb      = nbytes(size);
      ram_val = ram_read(addr, nb, sgn);
      check("req_ready_idle", 64'(req_ready), 64'(1));
      req_valid = 1'b1; req_we = we; req_size = size; req_sign = sgn;
      req_addr = addr; req_wdata = wdata; req_rd = rd;
      @(posedge clk);
      @(negedge clk);
      // scramble request fields: the stage must ignore them while busy
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      check("req_ready_busy", 64'(req_ready), 64'(0));
      if (exp_cause != 2'b00) begin
         check("exc_resp_valid", 64'({resp_valid, exc_valid}), 64'(2'b11));
         check("exc_cause", 64'(exc_cause), 64'(exp_cause));
         check("exc_addr", 64'(exc_addr), 64'(addr));
         check("exc_no_strobe", 64'({ram_we, ram_re, ram_type}), 64'(0));
      end else begin
         check("issue_strobe", 64'({ram_we, ram_re}), 64'({we, ~we}));
         check("issue_type", 64'(ram_type), 64'((1 << nb) - 1));
         check("issue_addr", 64'(ram_addr), 64'(addr));
         check("issue_sign", 64'(sign), 64'(we ? 1'b0 : sgn));
         if (we) check("issue_wdat", 64'(ram_wdat), 64'(wdata));
         check("issue_no_resp", 64'(resp_valid), 64'(0));
         data_reg = ~ram_val;
         @(negedge clk);
         check("post_issue_idle", 64'({ram_we, ram_re, sign, ram_type}), 64'(0));
         if (we) begin
            for (int i = 0; i < nb; i++) mem[addr + 32'(i)] = wdata[8*i +: 8];
         end else begin
            check("capture_no_resp", 64'(resp_valid), 64'(0));
            data_reg = ram_val;
            @(negedge clk);
            data_reg = $urandom;
         end
         check("resp_valid", 64'({resp_valid, exc_valid}), 64'(2'b10));
      end
      check("resp_rdata", 64'(resp_rdata), 64'(exp_rdata));
      check("resp_rd_is_load", 64'({resp_rd, resp_is_load}), 64'({rd, ~we}));
      resp_ready = (stall == 0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check("bp_hold", 64'({resp_valid, resp_rdata, exc_valid, exc_cause, req_ready}),
               64'({1'b1, exp_rdata, exp_cause != 2'b00, exp_cause, 1'b0}));
         if (i == stall - 1) resp_ready = 1'b1;
      end
      @(negedge clk);
      resp_ready = 1'b0;
      check("post_handshake", 64'({resp_valid, exc_valid, req_ready}), 64'(3'b001));
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_sign = 1'b0;
      req_addr = '0; req_wdata = '0; req_rd = '0; data_reg = '0; resp_ready = 1'b0;

      //           we    size   sgn   addr          wdata         rd     stall cause  rdata
      vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0044, 32'h0000_00B4, 5'd1,  0, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h0000_0044, 32'h0,         5'd2,  0, 2'b00, 32'h0000_00B4});
      vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0040, 32'h1234_F0F0, 5'd3,  1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0,         5'd4,  0, 2'b00, 32'h0000_F0F0});
      vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0,         5'd5,  0, 2'b00, 32'hFFFF_F0F0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0,         5'd6,  0, 2'b01, 32'h0});
      vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0045, 32'h0,         5'd7,  0, 2'b10, 32'h0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0,         5'd8,  0, RC,    32'h0});
      vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0,         5'd9,  5, 2'b00, 32'h0000_F0F0});
      vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0050, 32'hDEAD_BE85, 5'd10, 0, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0050, 32'h0,         5'd11, 0, 2'b00, 32'hFFFF_FF85});
      vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0050, 32'h0,         5'd12, 0, 2'b00, 32'h0000_0085});
      vecs.push_back('{1'b1, 2'b11, 1'b0, 32'h0000_1FFC, 32'hCAFE_F00D, 5'd13, 2, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_1FFC, 32'h0,         5'd14, 0, 2'b00, 32'hCAFE_F00D});
      vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_1FFE, 32'h0,         5'd15, 0, 2'b00, 32'hFFFF_CAFE});
      vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_1FFF, 32'h0,         5'd16, 0, 2'b01, 32'h0});
      vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_1FFE, 32'h0,         5'd17, 0, 2'b10, 32'h0});
      vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_2000, 32'h0000_0077, 5'd18, 0, RC,    32'h0});
      vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_1FFF, 32'h0,         5'd19, 1, 2'b00, 32'hFFFF_FFCA});

      repeat (2) @(negedge clk);
      check("rst_ctrl", 64'({req_ready, ram_we, ram_re, ram_type, sign, resp_valid, exc_valid, exc_cause}),
            64'(12'b1000_0000_0000));
      check("rst_ram_addr_wdat", {ram_addr, ram_wdat}, 64'(0));
      check("rst_resp", 64'({resp_rdata, resp_rd, resp_is_load, exc_addr}), 64'(0));
      rst = 1'b0;
      @(negedge clk);
      check("rst_release_idle", 64'({req_ready, resp_valid}), 64'(2'b10));

      foreach (vecs[i])
         run_txn(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, vecs[i].rd,
                 vecs[i].stall, vecs[i].exp_cause, vecs[i].exp_rdata);

      // reset asserted while a load is in ISSUE
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0;
      req_addr = 32'h44; req_rd = 5'd20;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_mid_issue_re", 64'(ram_re), 64'(1));
      #2 rst = 1'b1;
      #1;
      check("rst_mid_strobe_drop", 64'({ram_re, ram_we, ram_type, sign}), 64'(0));
      check("rst_mid_ready", 64'({req_ready, resp_valid}), 64'(2'b10));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("rst_mid_no_resp", 64'({resp_valid, req_ready}), 64'(2'b01));
      end
      run_txn(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, 5'd21, 0, 2'b00, ram_read(32'h42, 1, 1'b0));

      // random requests checked against the RAM/alignment model
      for (int n = 0; n < 80; n++) begin
         logic        we, sgn;
         logic [1:0]  size, cz;
         logic [31:0] addr, wdata, rdata;
         we    = 1'($urandom);
         sgn   = 1'($urandom);
         size  = 2'($urandom);
         addr  = (($urandom % 2) != 0 ? 32'h1FF0 : 32'h40) + 32'($urandom_range(0, 31));
         wdata = $urandom;
         cz    = model_cause(we, size, addr);
         rdata = (cz == 2'b00 && !we) ? ram_read(addr, nbytes(size), sgn) : 32'h0;
         run_txn(we, size, sgn, addr, wdata, 5'($urandom), $urandom_range(0, 2), cz, rdata);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control stage between execute and the data RAM (`ram_2`). It accepts one memory request at a time over a valid/ready handshake and checks alignment (plus address range when configured). It drives the RAM strobe, byte-type, sign, address and write-data lines for exactly one cycle per access. It returns load data, store completion or an exception to writeback over a second valid/ready handshake.

## Interface
- `DMEM_BYTES`, 8192: data RAM size in bytes; used only by the range check.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: stage idle, can accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `req_sign` in 1: 1 = sign-extend load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `req_rd` in 5: load destination register.
- `ram_we` out 1: RAM write strobe.
- `ram_re` out 1: RAM read strobe.
- `ram_type` out 4: 0001 byte, 0011 half, 1111 word, 0000 idle.
- `sign` out 1: RAM sign-extend select.
- `ram_addr` out 32: RAM address.
- `ram_wdat` out 32: RAM write data.
- `data_reg` in 32: RAM read data, already extended; valid the cycle after `ram_re`.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: writeback accepts.
- `resp_rdata` out 32: load result; 0 for stores and exceptions.
- `resp_rd` out 5: latched `req_rd`.
- `resp_is_load` out 1: response is for a load.
- `exc_valid` out 1: response carries an exception.
- `exc_cause` out 2: 01 load misaligned, 10 store misaligned, 11 access fault.
- `exc_addr` out 32: faulting address.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- **IDLE**
  - `req_ready` is 1.
  - On `req_valid`, the edge latches all `req_*` fields.
  - Next state is RESP with `exc_valid` set if the request faults; otherwise ISSUE.
- **ISSUE** (one cycle)
  - RAM outputs are driven from registers.
  - Exactly one of `ram_we`/`ram_re` is 1.
  - Store: next state RESP. Load: next state CAPTURE.
- **CAPTURE** (one cycle): the edge latches `data_reg` into `resp_rdata`; next state RESP.
- **RESP**: `resp_valid` is held until `resp_valid && resp_ready`, then the FSM returns to IDLE. No new request is accepted in this cycle.
- **Alignment rules**
  - Half access requires `addr[0]==0`.
  - Word access requires `addr[1:0]==00`.
  - Byte access is always aligned.
- A faulting request never asserts `ram_we`/`ram_re`.
- Outside ISSUE, `ram_we`, `ram_re` and `sign` are 0, and `ram_type` is 0000. `ram_addr` and `ram_wdat` hold their last value.
- `ram_wdat` = `req_wdata` unmodified; the RAM selects bytes by `ram_type`.
- `sign` = `req_sign` for loads and 0 for stores.

## Timing
- Reset values:
  - FSM state is IDLE.
  - `req_ready` = 1.
  - All other outputs are 0 (`ram_type` = 0000).
- Reset asserted mid-operation:
  - Strobes drop immediately (asynchronous).
  - The pending access and response are discarded.
- Latency is counted from the accept edge, T0:
  - Exception: `resp_valid` at T0+1.
  - Store: `ram_we` during T0+1, `resp_valid` at T0+2.
  - Load: `ram_re` during T0+1, `data_reg` sampled at the end of T0+2, `resp_valid` at T0+3.
- Throughput: one request per 3 cycles for stores and 4 cycles for loads, with no back-pressure.
- `resp_*` and `exc_*` fields are stable while `resp_valid` is high and `resp_ready` is low.
- `req_ready` is 0 in every state except IDLE.
- `req_*` inputs are ignored outside IDLE.

## Configuration
- `LSU_RANGE_CHECK_EN` defined:
  - An aligned request faults with cause 11 when `addr + bytes - 1 >= DMEM_BYTES`, where bytes is 1, 2 or 4.
  - Misalignment takes priority over the range fault.
- `LSU_RANGE_CHECK_EN` undefined: no range check; all aligned addresses are issued to the RAM.

## Test plan
- **Word store/load:**
  - Store 0x000000B4 to 0x44, then load word 0x44 with sign=1.
  - Required response: `ram_we` for 1 cycle with `ram_type`=1111, then `resp_rdata`=0x000000B4 at T0+3 with `resp_is_load`=1.
- **Half load, sign select:**
  - RAM returns 0x0000F0F0 for half 0x40 with sign=0, and 0xFFFFF0F0 with sign=1.
  - Required response: `sign` output matches `req_sign` during ISSUE, and `resp_rdata` equals `data_reg`.
- **Misaligned requests:**
  - Load word 0x42 -> `exc_valid`=1, `exc_cause`=01, `exc_addr`=0x42 at T0+1, no RAM strobe.
  - Store half 0x45 -> `exc_cause`=10.
- **Range check:**
  - With `LSU_RANGE_CHECK_EN`: load word 0x2000 -> `exc_cause`=11, no strobe.
  - Without it: `ram_re`=1 with `ram_addr`=0x2000.
- **Back-pressure:**
  - Hold `resp_ready`=0 for 5 cycles after a load of 0x40.
  - Required response: `resp_valid` and `resp_rdata` stay stable, `req_ready` stays 0, and the next request is accepted the cycle after the handshake.
- **Reset mid-load:**
  - Assert `rst` during ISSUE.
  - Required response: `ram_re` falls immediately and `resp_valid` stays 0. After release, `req_ready`=1 and a byte load of 0x42 completes normally.
